// File: rtl/cmsdk_apb_window_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_apb_window_watchdog
// Purpose  : Multi-channel windowed APB watchdog. NUM_CH independent
//            down-counters share one programmable prescaler. Each channel has
//            load, control, window, raw and masked status registers, an
//            interrupt and a sticky reset request. Refreshing a channel while
//            its count is still above the window is an early-refresh
//            violation.
// Ports    : PCLK        - clock for APB and counters
//            PRESET      - asynchronous active-high reset
//            PSEL/PENABLE/PADDR/PWRITE/PWDATA - APB slave request
//            PRDATA      - registered read data, valid in the access phase
//            PREADY      - always 1
//            PSLVERR     - write blocked by the lock
//            WDOGINT     - per-channel interrupt (masked status)
//            WDOGRES     - per-channel sticky reset request
//            WDOGRES_ANY - OR of WDOGRES
// Revision : 1.0 - initial release
// ============================================================================
module cmsdk_apb_window_watchdog #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [11:2]       PADDR,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] WDOGINT,
  output logic [NUM_CH-1:0] WDOGRES,
  output logic              WDOGRES_ANY
);

  localparam logic [31:0] c_unlock_key = 32'h1ACC_E551;
  localparam logic [9:0]  c_addr_lock  = 10'h300;  // 0xC00
  localparam logic [9:0]  c_addr_presc = 10'h301;  // 0xC04

  localparam logic [2:0] c_off_load   = 3'd0;
  localparam logic [2:0] c_off_value  = 3'd1;
  localparam logic [2:0] c_off_ctrl   = 3'd2;
  localparam logic [2:0] c_off_intclr = 3'd3;
  localparam logic [2:0] c_off_ris    = 3'd4;
  localparam logic [2:0] c_off_mis    = 3'd5;
  localparam logic [2:0] c_off_window = 3'd6;

  // CTRL bit positions
  localparam int c_inten = 0;
  localparam int c_resen = 1;
  localparam int c_winen = 2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                   r_locked;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] r_presc_cnt;
  logic [CNT_WIDTH-1:0]   r_load   [NUM_CH];
  logic [CNT_WIDTH-1:0]   r_value  [NUM_CH];
  logic [CNT_WIDTH-1:0]   r_window [NUM_CH];
  logic [2:0]             r_ctrl   [NUM_CH];
  logic [NUM_CH-1:0]      r_ris;
  logic [NUM_CH-1:0]      r_res;
  logic [31:0]            r_prdata;
  logic                   r_pslverr;

  // --------------------------------------------------------------------------
  // APB decode
  // --------------------------------------------------------------------------
  logic              w_setup;
  logic              w_wr;
  logic              w_rd;
  logic              w_lock_sel;
  logic              w_presc_sel;
  logic              w_blocked;
  logic              w_wr_ok;
  logic              w_tick;
  logic [NUM_CH-1:0] w_ch_sel;
  logic [NUM_CH-1:0] w_wr_load;
  logic [NUM_CH-1:0] w_wr_ctrl;
  logic [NUM_CH-1:0] w_wr_intclr;
  logic [NUM_CH-1:0] w_wr_window;
  logic [31:0]       w_rdata;

  assign w_setup     = PSEL & ~PENABLE;
  assign w_wr        = w_setup & PWRITE;
  assign w_rd        = w_setup & ~PWRITE;
  assign w_lock_sel  = (PADDR == c_addr_lock);
  assign w_presc_sel = (PADDR == c_addr_presc);
  // Every write other than to LOCK is dropped while locked, mapped or not.
  assign w_blocked   = w_wr & r_locked & ~w_lock_sel;
  assign w_wr_ok     = w_wr & ~w_blocked;

  // Channel n occupies byte addresses n*0x20 .. n*0x20+0x1F in the low 256 bytes.
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch_decode
      assign w_ch_sel[g]    = (PADDR[11:8] == 4'd0) && (PADDR[7:5] == 3'(g));
      assign w_wr_load[g]   = w_wr_ok & w_ch_sel[g] & (PADDR[4:2] == c_off_load);
      assign w_wr_ctrl[g]   = w_wr_ok & w_ch_sel[g] & (PADDR[4:2] == c_off_ctrl);
      assign w_wr_intclr[g] = w_wr_ok & w_ch_sel[g] & (PADDR[4:2] == c_off_intclr);
      assign w_wr_window[g] = w_wr_ok & w_ch_sel[g] & (PADDR[4:2] == c_off_window);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read mux (zero-extended to 32 bits)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    if (w_lock_sel) begin
      w_rdata[0] = r_locked;
    end else if (w_presc_sel) begin
      w_rdata[PRESC_WIDTH-1:0] = r_presc;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ch_sel[n]) begin
        case (PADDR[4:2])
          c_off_load:   w_rdata[CNT_WIDTH-1:0] = r_load[n];
          c_off_value:  w_rdata[CNT_WIDTH-1:0] = r_value[n];
          c_off_ctrl:   w_rdata[2:0]           = r_ctrl[n];
          c_off_ris:    w_rdata[0]             = r_ris[n];
          c_off_mis:    w_rdata[0]             = r_ris[n] & r_ctrl[n][c_inten];
          c_off_window: w_rdata[CNT_WIDTH-1:0] = r_window[n];
          default:      w_rdata                = '0;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus response, lock and prescaler
  // --------------------------------------------------------------------------
  assign w_tick = (r_presc_cnt == r_presc);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_prdata    <= '0;
      r_pslverr   <= 1'b0;
      r_locked    <= 1'b0;
      r_presc     <= '0;
      r_presc_cnt <= '0;
    end else begin
      // Registered in the setup phase so the data/error appear in the access
      // phase and drop back to 0 in every other cycle.
      r_prdata  <= w_rd ? w_rdata : 32'd0;
      r_pslverr <= w_blocked;

      if (w_wr && w_lock_sel) begin
        r_locked <= (PWDATA != c_unlock_key);
      end

      if (w_wr_ok && w_presc_sel) begin
        r_presc     <= PWDATA[PRESC_WIDTH-1:0];
        r_presc_cnt <= '0;
      end else if (w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Channel counters
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_load[n]   <= '1;
        r_value[n]  <= '1;
        r_window[n] <= '1;
        r_ctrl[n]   <= '0;
      end
      r_ris <= '0;
      r_res <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        // A LOAD or INTCLR write overrides a coincident tick for this channel.
        if (w_wr_load[n]) begin
          r_load[n]  <= PWDATA[CNT_WIDTH-1:0];
          r_value[n] <= PWDATA[CNT_WIDTH-1:0];
        end else if (w_wr_intclr[n]) begin
          r_ris[n]   <= 1'b0;
          r_value[n] <= r_load[n];
          // Early refresh: the count has not yet fallen into the window.
          if (r_ctrl[n][c_winen] && r_ctrl[n][c_resen] && (r_value[n] > r_window[n])) begin
            r_res[n] <= 1'b1;
          end
        end else if (w_tick && r_ctrl[n][c_inten]) begin
          if (r_value[n] == '0) begin
            r_value[n] <= r_load[n];
            if (!r_ris[n]) begin
              r_ris[n] <= 1'b1;
            end else if (r_ctrl[n][c_resen]) begin
              r_res[n] <= 1'b1;
            end
          end else begin
            r_value[n] <= r_value[n] - CNT_WIDTH'(1);
          end
        end

        // Placed last so a CTRL write with RESEN=0 clears the request even if
        // an event would have set it on the same edge.
        if (w_wr_ctrl[n]) begin
          r_ctrl[n] <= PWDATA[2:0];
          if (!PWDATA[c_resen]) begin
            r_res[n] <= 1'b0;
          end
        end

        if (w_wr_window[n]) begin
          r_window[n] <= PWDATA[CNT_WIDTH-1:0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_int_out
      assign WDOGINT[g] = r_ris[g] & r_ctrl[g][c_inten];
    end
  endgenerate

  assign WDOGRES     = r_res;
  assign WDOGRES_ANY = |r_res;
  assign PRDATA      = r_prdata;
  assign PSLVERR     = r_pslverr;
  assign PREADY      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_apb_window_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmsdk_apb_window_watchdog
// Purpose  : Self-checking bench for cmsdk_apb_window_watchdog. A
//            register-level model tracks the watchdog from the bus traffic and
//            is compared with every output on every cycle; directed
//            sequences add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmsdk_apb_window_watchdog;

  localparam int NCH = 4;
  localparam logic [31:0] KEY = 32'h1ACC_E551;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [11:2] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [NCH-1:0] WDOGINT;
  logic [NCH-1:0] WDOGRES;
  logic        WDOGRES_ANY;

  cmsdk_apb_window_watchdog #(.NUM_CH(NCH), .CNT_WIDTH(32), .PRESC_WIDTH(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .WDOGINT(WDOGINT), .WDOGRES(WDOGRES), .WDOGRES_ANY(WDOGRES_ANY)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Model: register file view of the watchdog
  // --------------------------------------------------------------------------
  logic [31:0] m_load [NCH];
  logic [31:0] m_value[NCH];
  logic [31:0] m_win  [NCH];
  logic [2:0]  m_ctrl [NCH];
  logic        m_ris  [NCH];
  logic        m_res  [NCH];
  logic        m_locked;
  logic [7:0]  m_presc;
  logic [7:0]  m_pcnt;
  logic [31:0] exp_prdata;
  logic        exp_pslverr;
  bit          m_valid = 0;

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int ch, off;
    if (a == 12'hC00) return {31'd0, m_locked};
    if (a == 12'hC04) return {24'd0, m_presc};
    ch  = int'(a) / 32;
    off = (int'(a) % 32) / 4;
    if (ch >= NCH) return 32'd0;
    case (off)
      0: return m_load[ch];
      1: return m_value[ch];
      2: return {29'd0, m_ctrl[ch]};
      4: return {31'd0, m_ris[ch]};
      5: return {31'd0, m_ris[ch] & m_ctrl[ch][0]};
      6: return m_win[ch];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_load[c] = '1; m_value[c] = '1; m_win[c] = '1;
      m_ctrl[c] = '0; m_ris[c] = 0; m_res[c] = 0;
    end
    m_locked = 0; m_presc = 0; m_pcnt = 0;
    exp_prdata = 0; exp_pslverr = 0;
    m_valid = 1;
  endtask

  task automatic model_step();
    logic [11:0] a;
    logic setup, wr, tick, blocked, do_wr, hit;
    logic [31:0] old_v;
    logic        old_ris;
    logic [2:0]  old_ctrl;
    int off;
    a       = {PADDR, 2'b00};
    setup   = PSEL && !PENABLE;
    wr      = setup && PWRITE;
    tick    = (m_pcnt == m_presc);
    blocked = wr && m_locked && (a != 12'hC00);
    do_wr   = wr && !blocked;
    off     = (int'(a) % 32) / 4;

    exp_prdata  = (setup && !PWRITE) ? model_read(a) : 32'd0;
    exp_pslverr = blocked;

    if (do_wr && a == 12'hC04) begin
      m_presc = PWDATA[7:0];
      m_pcnt  = 0;
    end else begin
      m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
    end
    if (wr && a == 12'hC00) m_locked = (PWDATA != KEY);

    for (int c = 0; c < NCH; c++) begin
      hit      = do_wr && (int'(a) / 32 == c);
      old_v    = m_value[c];
      old_ris  = m_ris[c];
      old_ctrl = m_ctrl[c];
      if (hit && off == 0) begin
        m_load[c] = PWDATA; m_value[c] = PWDATA;
      end else if (hit && off == 3) begin
        m_ris[c] = 0; m_value[c] = m_load[c];
        if (old_ctrl[2] && old_ctrl[1] && old_v > m_win[c]) m_res[c] = 1;
      end else if (tick && old_ctrl[0]) begin
        if (old_v == 0) begin
          m_value[c] = m_load[c];
          if (!old_ris) m_ris[c] = 1;
          else if (old_ctrl[1]) m_res[c] = 1;
        end else begin
          m_value[c] = old_v - 1;
        end
      end
      if (hit && off == 2) begin
        m_ctrl[c] = PWDATA[2:0];
        if (!PWDATA[1]) m_res[c] = 0;
      end
      if (hit && off == 6) m_win[c] = PWDATA;
    end
  endtask

  // Model update and per-cycle comparison
  initial begin
    logic [NCH-1:0] e_int, e_res;
    forever begin
      @(posedge PCLK or posedge PRESET);
      if (PRESET) model_reset();
      else if (m_valid) model_step();
      #1;
      if (m_valid) begin
        for (int c = 0; c < NCH; c++) begin
          e_int[c] = m_ris[c] & m_ctrl[c][0];
          e_res[c] = m_res[c];
        end
        check("cyc_PRDATA",  PRDATA, exp_prdata);
        check("cyc_PSLVERR", {31'd0, PSLVERR}, {31'd0, exp_pslverr});
        check("cyc_WDOGINT", {28'd0, WDOGINT}, {28'd0, e_int});
        check("cyc_WDOGRES", {28'd0, WDOGRES}, {28'd0, e_res});
        check("cyc_RES_ANY", {31'd0, WDOGRES_ANY}, {31'd0, |e_res});
        check("cyc_PREADY",  {31'd0, PREADY}, 32'd1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus tasks
  // --------------------------------------------------------------------------
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a[11:2]; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1;
    err = PSLVERR;
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a[11:2];
    @(negedge PCLK);
    PENABLE = 1;
    d = PRDATA;
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // Counts clock edges until WDOGINT[idx] (which=0) or WDOGRES[idx] (which=1) is high.
  task automatic wait_out(input string name, input int which, input int idx, output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge PCLK); #1; cnt++;
      if (((which == 0) ? WDOGINT[idx] : WDOGRES[idx]) === 1'b1) return;
    end
    n_checks++;
    $display("FAIL %s: timeout after %0d cycles, output never rose", name, cnt);
    cnt = -1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequences
  // --------------------------------------------------------------------------
  initial begin
    logic        err;
    logic [31:0] d, v1, v2;
    int          cnt;

    repeat (3) @(negedge PCLK);
    PRESET = 0;

    // Reset state
    apb_read(12'h000, d); check("rst_LOAD0", d, 32'hFFFF_FFFF);
    apb_read(12'h008, d); check("rst_CTRL0", d, 32'd0);
    apb_read(12'hC00, d); check("rst_LOCK",  d, 32'd0);

    // 1: ch0 LOAD=3, run; interrupt after VALUE 3,2,1,0 then reload
    apb_write(12'h000, 32'd3, err);
    apb_write(12'h008, 32'd1, err);
    wait_out("t1_int_wait", 0, 0, cnt);
    check("t1_int_latency", cnt, 32'd3);
    check("t1_no_res", {28'd0, WDOGRES}, 32'd0);

    // 2: with RESEN and no clear, reset request at the next zero
    apb_write(12'h008, 32'd0, err);
    apb_write(12'h00C, 32'd0, err);
    apb_write(12'h008, 32'd3, err);
    wait_out("t2_int_wait", 0, 0, cnt);
    check("t2_int_latency", cnt, 32'd3);
    wait_out("t2_res_wait", 1, 0, cnt);
    check("t2_res_latency", cnt, 32'd4);
    check("t2_res_any", {31'd0, WDOGRES_ANY}, 32'd1);
    apb_write(12'h008, 32'd1, err);
    check("t2_res_cleared", {28'd0, WDOGRES}, 32'd0);
    apb_write(12'h008, 32'd0, err);

    // 3: ch1 windowed refresh
    apb_write(12'h020, 32'd100, err);
    apb_write(12'h038, 32'd20, err);
    apb_write(12'h028, 32'd7, err);
    idle(88);                                   // refresh lands at VALUE=10
    apb_write(12'h02C, 32'd0, err);
    check("t3_late_no_res", {28'd0, WDOGRES}, 32'd0);
    apb_read(12'h024, d); check("t3_reload_value", d, 32'd98);
    apb_read(12'h030, d); check("t3_ris_clear", d, 32'd0);
    idle(42);                                   // refresh lands at VALUE=50
    apb_write(12'h02C, 32'd0, err);
    check("t3_early_res", {28'd0, WDOGRES}, 32'h2);
    check("t3_early_any", {31'd0, WDOGRES_ANY}, 32'd1);
    apb_read(12'h024, d); check("t3_early_reload", d, 32'd98);

    // 4: lock
    apb_write(12'hC00, 32'd0, err);
    apb_write(12'h000, 32'd5, err);
    check("t4_locked_err", {31'd0, err}, 32'd1);
    apb_read(12'h000, d); check("t4_locked_load", d, 32'd3);
    apb_read(12'hC00, d); check("t4_lock_state", d, 32'd1);
    apb_write(12'hC00, KEY, err);
    check("t4_unlock_err", {31'd0, err}, 32'd0);
    apb_write(12'h000, 32'd5, err);
    check("t4_load_err", {31'd0, err}, 32'd0);
    apb_read(12'h000, d); check("t4_load_rb", d, 32'd5);
    apb_read(12'h004, d); check("t4_value_rb", d, 32'd5);
    apb_read(12'h01C, d); check("unmapped_rsvd", d, 32'd0);
    apb_read(12'h0A0, d); check("unmapped_ch5", d, 32'd0);
    apb_read(12'h800, d); check("unmapped_800", d, 32'd0);

    // 5: prescaler
    apb_write(12'h000, 32'd200, err);
    apb_write(12'hC04, 32'd3, err);
    apb_read(12'hC04, d); check("t5_presc_rb", d, 32'd3);
    apb_write(12'h008, 32'd1, err);
    apb_read(12'h004, v1);
    idle(5);
    apb_read(12'h004, v2);
    check("t5_8cyc_delta", v1 - v2, 32'd2);
    apb_write(12'hC04, 32'd3, err);
    apb_read(12'h004, v1);
    idle(2);
    apb_read(12'h004, v2);
    check("t5_restart_delta", v1 - v2, 32'd1);

    // LOAD=0: event on every tick, VALUE stays 0
    apb_write(12'h040, 32'd0, err);
    apb_write(12'h048, 32'd1, err);
    wait_out("load0_int_wait", 0, 2, cnt);
    apb_read(12'h050, d); check("load0_ris", d, 32'd1);
    apb_read(12'h044, d); check("load0_value", d, 32'd0);

    // 6: asynchronous reset mid-count with a reset request pending
    check("t6_pre_any", {31'd0, WDOGRES_ANY}, 32'd1);
    apb_write(12'hC00, 32'd0, err);             // lock, must clear on reset
    @(posedge PCLK); #3;
    PRESET = 1;
    #1;
    check("t6_res",    {28'd0, WDOGRES}, 32'd0);
    check("t6_any",    {31'd0, WDOGRES_ANY}, 32'd0);
    check("t6_int",    {28'd0, WDOGINT}, 32'd0);
    check("t6_prdata", PRDATA, 32'd0);
    @(negedge PCLK);
    PRESET = 0;
    apb_read(12'h000, d); check("t6_load",   d, 32'hFFFF_FFFF);
    apb_read(12'hC00, d); check("t6_lock",   d, 32'd0);
    apb_read(12'h018, d); check("t6_window", d, 32'hFFFF_FFFF);
    apb_write(12'h000, 32'd9, err);
    check("t6_unlocked_err", {31'd0, err}, 32'd0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
